capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter FRAME_PIXELS, default 76800, is the number of pixels in one complete 240x320 rotated frame.
REQ-002 Parameter RETRY_MAX, default 3, is the number of consecutive short or long frames allowed before the capture is aborted.
REQ-003 clk_in  input  1  system pixel clock (65 MHz); the only clock.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 capture_in  input  1  capture request level (debounced button); acted on at its rising edge.
REQ-006 release_in  input  1  release level; acted on at its rising edge.
REQ-007 pixel_valid_in  input  1  one-cycle strobe for each rotated camera pixel, synchronous to clk_in.
REQ-008 frame_done_in  input  1  one-cycle end-of-frame strobe from the camera.
REQ-009 we_out  output  1  frame-buffer write enable.
REQ-010 state_out  output  2  current state: LIVE=0, ARMED=1, CAPTURE=2, HOLD=3.
REQ-011 frozen_out  output  1  high when the buffer holds a complete frozen frame.
REQ-012 capture_done_out  output  1  one-cycle pulse when a frame has been frozen.
REQ-013 error_out  output  1  sticky flag set when a capture is aborted.
REQ-014 pixel_count_out  output  17  number of pixels written in the current or most recent capture.

Function
REQ-015 The block SHALL drive we_out combinationally as pixel_valid_in AND write_allowed, where write_allowed is a registered signal derived from the state.
REQ-016 LIVE state:
- write_allowed=1.
- A capture_in rising edge SHALL move the FSM to ARMED.
REQ-017 ARMED state:
- write_allowed=1.
- The FSM SHALL wait for frame_done_in, then go to CAPTURE and clear pixel_count to 0 on that same edge.
REQ-018 CAPTURE state:
- write_allowed=1 while pixel_count < FRAME_PIXELS.
- Each we_out cycle SHALL increment pixel_count by 1.
- Excess pixels SHALL NOT be written, and the count SHALL saturate at FRAME_PIXELS+1 to mark an overlong frame.
REQ-019 On frame_done_in in CAPTURE with pixel_count == FRAME_PIXELS:
- The FSM SHALL go to HOLD.
- capture_done_out SHALL pulse in the next cycle.
- The retry counter SHALL clear.
REQ-020 On frame_done_in in CAPTURE with pixel_count != FRAME_PIXELS:
- The retry counter SHALL increment.
- If the retry counter is below RETRY_MAX, the FSM SHALL stay in CAPTURE with pixel_count cleared to 0.
- Otherwise the FSM SHALL go to LIVE, set error_out, and clear the retry counter.
REQ-021 HOLD state:
- write_allowed=0 and frozen_out=1.
- capture_in edges SHALL be ignored.
- A release_in rising edge SHALL move the FSM to LIVE.
REQ-022 A release_in rising edge in ARMED or CAPTURE SHALL abort to LIVE without setting error_out.
REQ-023 If capture_in and release_in rise in the same cycle, release SHALL win in every state, and LIVE SHALL stay in LIVE.
REQ-024 If a pixel_valid_in and a frame_done_in coincide in CAPTURE, the pixel SHALL be counted before the length check, and the length check SHALL use the incremented count.
REQ-025 A new capture_in rising edge in LIVE SHALL clear error_out.
REQ-026 pixel_count_out SHALL hold its value in LIVE and HOLD, so the last capture length stays visible.
REQ-027 Edge detection SHALL use one registered copy of each of capture_in and release_in; an input already high when reset releases SHALL NOT create an edge.

Reset
REQ-028 While rst_in is high at a clk_in edge, the block SHALL set:
- state LIVE, write_allowed=1, frozen_out=0;
- capture_done_out=0, error_out=0;
- pixel_count=0, retry counter=0;
- edge registers = current input levels.
REQ-029 Reset asserted mid-CAPTURE or in HOLD SHALL return the FSM to LIVE on the next edge, with no capture_done_out pulse.

Structure
REQ-030 The state enum, its 2-bit encoding and the FRAME_PIXELS default SHALL live in a shared package, capture_pkg, so display and top-level logic can decode state_out.
REQ-031 Both edge detectors SHALL be instances of a single sub-module named rising_edge_detect.
REQ-032 The block SHALL contain no multipliers and no memories; the target size is roughly 150-250 lines of RTL.

Verification
REQ-033 Normal capture: capture_in rise, one frame_done, exactly 76800 pixel strobes, frame_done -> state_out=3, capture_done_out high for one cycle, pixel_count_out=76800, we_out=0 for any later strobe.
REQ-034 Short frame retry: in CAPTURE, 76799 strobes then frame_done -> state stays 2, count resets to 0; a following full 76800-pixel frame -> HOLD.
REQ-035 Abort on retries: RETRY_MAX=3 and three consecutive 76801-strobe frames -> only 76800 writes per frame, state_out=0, error_out=1; the next capture_in rise -> error_out=0.
REQ-036 Release: in HOLD, release_in rise -> state_out=0 the next cycle, frozen_out=0, and we_out follows pixel_valid_in.
REQ-037 Simultaneous events: capture_in and release_in rise together in ARMED -> state LIVE; strobe coincident with the closing frame_done at count 76799 -> HOLD.
REQ-038 Reset mid-capture: rst_in high at count 40000 -> state_out=0, pixel_count_out=0, no capture_done_out pulse; capture_in held high through reset -> no capture starts.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the frame-capture controller: state encoding and frame geometry.
package capture_pkg;
  typedef enum logic [1:0] {
    LIVE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int DEFAULT_FRAME_PIXELS = 76800;
  localparam int CNT_W                = 17;
endpackage

// File: rtl/capture_ctrl_if.sv
// Camera/frame-buffer handshake bundle for capture_ctrl; master drives the camera side.
interface capture_ctrl_if;
  import capture_pkg::*;

  logic             capture_in;
  logic             release_in;
  logic             pixel_valid_in;
  logic             frame_done_in;
  logic             we_out;
  logic [1:0]       state_out;
  logic             frozen_out;
  logic             capture_done_out;
  logic             error_out;
  logic [CNT_W-1:0] pixel_count_out;

  modport master (
    output capture_in, release_in, pixel_valid_in, frame_done_in,
    input  we_out, state_out, frozen_out, capture_done_out, error_out, pixel_count_out
  );

  modport slave (
    input  capture_in, release_in, pixel_valid_in, frame_done_in,
    output we_out, state_out, frozen_out, capture_done_out, error_out, pixel_count_out
  );
endinterface

// File: rtl/rising_edge_detect.sv
// Single-register rising-edge detector; reset loads the current level so a held input gives no edge.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk) begin
    prev <= level;
  end

  assign rise = level & ~prev & ~rst;
endmodule

// File: rtl/capture_ctrl.sv
// Freezes one complete camera frame in the frame buffer on request, retrying short/long frames.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
  parameter int RETRY_MAX    = 3
) (
  input logic           clk_in,
  input logic           rst_in,
  capture_ctrl_if.slave bus
);
  localparam int                 RETRY_W   = $clog2(RETRY_MAX + 1);
  localparam logic [CNT_W-1:0]   FULL      = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0]   OVER      = CNT_W'(FRAME_PIXELS + 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  state_t             state;
  logic               write_allowed;
  logic               frozen;
  logic               done;
  logic               error;
  logic [CNT_W-1:0]   pixel_count;
  logic [CNT_W-1:0]   cnt_inc;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_inc;
  logic               cap_rise;
  logic               rel_rise;

  rising_edge_detect u_cap_edge (
    .clk   (clk_in),
    .rst   (rst_in),
    .level (bus.capture_in),
    .rise  (cap_rise)
  );

  rising_edge_detect u_rel_edge (
    .clk   (clk_in),
    .rst   (rst_in),
    .level (bus.release_in),
    .rise  (rel_rise)
  );

  // Pixel counted before the length check; stops one past full to flag an overlong frame.
  always_comb begin
    cnt_inc = pixel_count;
    if (state == CAPTURE && bus.pixel_valid_in && pixel_count < OVER)
      cnt_inc = pixel_count + 1'b1;
  end

  assign retry_inc = retry + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= LIVE;
      write_allowed <= 1'b1;
      frozen        <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      pixel_count   <= '0;
      retry         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LIVE: begin
          write_allowed <= 1'b1;
          if (cap_rise && !rel_rise) begin
            state <= ARMED;
            error <= 1'b0;
          end
        end
        ARMED: begin
          if (rel_rise) begin
            state <= LIVE;
          end else if (bus.frame_done_in) begin
            state       <= CAPTURE;
            pixel_count <= '0;
            retry       <= '0;
          end
        end
        CAPTURE: begin
          if (rel_rise) begin
            state         <= LIVE;
            write_allowed <= 1'b1;
            retry         <= '0;
          end else if (bus.frame_done_in) begin
            if (cnt_inc == FULL) begin
              state         <= HOLD;
              pixel_count   <= cnt_inc;
              write_allowed <= 1'b0;
              frozen        <= 1'b1;
              done          <= 1'b1;
              retry         <= '0;
            end else if (retry_inc < RETRY_LIM) begin
              pixel_count   <= '0;
              write_allowed <= 1'b1;
              retry         <= retry_inc;
            end else begin
              state         <= LIVE;
              pixel_count   <= cnt_inc;
              write_allowed <= 1'b1;
              error         <= 1'b1;
              retry         <= '0;
            end
          end else begin
            pixel_count   <= cnt_inc;
            write_allowed <= (cnt_inc < FULL);
          end
        end
        HOLD: begin
          if (rel_rise) begin
            state         <= LIVE;
            frozen        <= 1'b0;
            write_allowed <= 1'b1;
          end
        end
        default: state <= LIVE;
      endcase
    end
  end

  assign bus.we_out           = bus.pixel_valid_in & write_allowed;
  assign bus.state_out        = state;
  assign bus.frozen_out       = frozen;
  assign bus.capture_done_out = done;
  assign bus.error_out        = error;
  assign bus.pixel_count_out  = pixel_count;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl using a reduced frame size so full frames stay short.
module tb_capture_ctrl;
  import capture_pkg::*;

  localparam int FP  = 64;
  localparam int RM  = 3;
  localparam int BIG = 1 << 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   exp_q[$];

  always #5 clk = ~clk;

  capture_ctrl_if bus ();

  capture_ctrl #(.FRAME_PIXELS(FP), .RETRY_MAX(RM)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n strobes; frame position start+i below limit is expected to write.
  task automatic pixels(input int n, input int start, input int limit, input string tag,
                        output int writes);
    bit e;
    writes = 0;
    for (int i = 0; i < n; i++) begin
      bus.pixel_valid_in = 1'b1;
      exp_q.push_back((start + i) < limit);
      #1;
      e = exp_q.pop_front();
      chk(tag, bus.we_out, e);
      if (bus.we_out) writes++;
      tick();
    end
    bus.pixel_valid_in = 1'b0;
  endtask

  task automatic cap_pulse();
    bus.capture_in = 1'b1;
    tick();
    bus.capture_in = 1'b0;
  endtask

  task automatic rel_pulse();
    bus.release_in = 1'b1;
    tick();
    bus.release_in = 1'b0;
  endtask

  task automatic fd_pulse();
    bus.frame_done_in = 1'b1;
    tick();
    bus.frame_done_in = 1'b0;
  endtask

  initial begin
    int w;
    bus.capture_in     = 1'b0;
    bus.release_in     = 1'b0;
    bus.pixel_valid_in = 1'b0;
    bus.frame_done_in  = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_state", bus.state_out, LIVE);
    chk("rst_frozen", bus.frozen_out, 0);
    chk("rst_done", bus.capture_done_out, 0);
    chk("rst_error", bus.error_out, 0);
    chk("rst_count", bus.pixel_count_out, 0);
    pixels(4, 0, BIG, "live_we", w);

    // Normal capture
    cap_pulse();
    chk("armed", bus.state_out, ARMED);
    pixels(2, 0, BIG, "armed_we", w);
    fd_pulse();
    chk("enter_capture", bus.state_out, CAPTURE);
    chk("enter_count", bus.pixel_count_out, 0);
    pixels(FP, 0, FP, "cap_we", w);
    chk("cap_writes", w, FP);
    fd_pulse();
    chk("hold_state", bus.state_out, HOLD);
    chk("hold_done", bus.capture_done_out, 1);
    chk("hold_count", bus.pixel_count_out, FP);
    chk("hold_frozen", bus.frozen_out, 1);
    tick();
    chk("done_one_cycle", bus.capture_done_out, 0);
    pixels(3, 0, 0, "hold_we", w);
    cap_pulse();
    chk("hold_ignore_cap", bus.state_out, HOLD);
    rel_pulse();
    chk("release_state", bus.state_out, LIVE);
    chk("release_frozen", bus.frozen_out, 0);
    chk("live_count_kept", bus.pixel_count_out, FP);
    pixels(2, 0, BIG, "post_release_we", w);

    // Short frame then full frame
    cap_pulse();
    fd_pulse();
    pixels(FP - 1, 0, FP, "short_we", w);
    fd_pulse();
    chk("short_state", bus.state_out, CAPTURE);
    chk("short_count", bus.pixel_count_out, 0);
    chk("short_no_done", bus.capture_done_out, 0);
    pixels(FP, 0, FP, "retry_we", w);
    fd_pulse();
    chk("retry_hold", bus.state_out, HOLD);
    chk("retry_done", bus.capture_done_out, 1);
    rel_pulse();

    // Three overlong frames abort with error
    cap_pulse();
    fd_pulse();
    for (int f = 0; f < RM; f++) begin
      pixels(FP + 1, 0, FP, "long_we", w);
      chk("long_writes", w, FP);
      chk("long_sat", bus.pixel_count_out, FP + 1);
      fd_pulse();
      if (f < RM - 1) begin
        chk("long_retry_state", bus.state_out, CAPTURE);
        chk("long_retry_count", bus.pixel_count_out, 0);
      end
    end
    chk("abort_state", bus.state_out, LIVE);
    chk("abort_error", bus.error_out, 1);
    chk("abort_no_done", bus.capture_done_out, 0);
    tick();
    chk("error_sticky", bus.error_out, 1);
    cap_pulse();
    chk("error_clear", bus.error_out, 0);
    chk("rearm_state", bus.state_out, ARMED);

    // Simultaneous capture/release edges
    bus.capture_in = 1'b1;
    bus.release_in = 1'b1;
    tick();
    chk("both_armed", bus.state_out, LIVE);
    bus.capture_in = 1'b0;
    bus.release_in = 1'b0;
    tick();
    bus.capture_in = 1'b1;
    bus.release_in = 1'b1;
    tick();
    chk("both_live", bus.state_out, LIVE);
    bus.capture_in = 1'b0;
    bus.release_in = 1'b0;
    tick();

    // Release aborts CAPTURE without error
    cap_pulse();
    fd_pulse();
    pixels(5, 0, FP, "abort_cap_we", w);
    rel_pulse();
    chk("rel_cap_state", bus.state_out, LIVE);
    chk("rel_cap_error", bus.error_out, 0);

    // Strobe coincident with the closing frame_done
    cap_pulse();
    fd_pulse();
    pixels(FP - 1, 0, FP, "coinc_we", w);
    bus.pixel_valid_in = 1'b1;
    bus.frame_done_in  = 1'b1;
    #1;
    chk("coinc_last_we", bus.we_out, 1);
    tick();
    bus.pixel_valid_in = 1'b0;
    bus.frame_done_in  = 1'b0;
    chk("coinc_state", bus.state_out, HOLD);
    chk("coinc_count", bus.pixel_count_out, FP);
    chk("coinc_done", bus.capture_done_out, 1);
    rel_pulse();

    // Reset mid-capture with capture held high
    cap_pulse();
    fd_pulse();
    pixels(FP / 2, 0, FP, "mid_we", w);
    chk("mid_count", bus.pixel_count_out, FP / 2);
    bus.capture_in = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", bus.state_out, LIVE);
    chk("midrst_count", bus.pixel_count_out, 0);
    chk("midrst_done", bus.capture_done_out, 0);
    tick();
    chk("held_cap_state", bus.state_out, LIVE);
    chk("held_cap_done", bus.capture_done_out, 0);
    tick();
    chk("held_cap_state2", bus.state_out, LIVE);
    bus.capture_in = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
